verinject_injection_sequencer: RTL and testbench

- Drives the `verinject__injector_state` bus read by every flip-flop and memory injector in an instrumented design.
- A host (testbench or campaign controller) queues timed injection commands, each a (cycle, global bit index) pair.
- The sequencer keeps a free-running cycle counter. When the counter reaches a command's cycle, it presents that command's bit index on the state bus for exactly one clock.
- At all other times it presents the idle code, which matches no injector.

---
 rtl/verinject_injection_sequencer.sv | 226 ++++++++++++++++++++++
 tb/tb_verinject_injection_sequencer.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/verinject_injection_sequencer.sv
// Injection sequencer for an instrumented design.
// A host queues timed (cycle, bit index) commands into a small FIFO. A
// free-running cycle counter advances while run is high, and when the head
// command's timestamp has been reached its bit index is placed on the
// injector state bus for exactly one clock. At all other times the bus
// carries IDLE_CODE, which matches no injector. The counter saturates at its
// maximum value and the block halts there until reset or clear.
// DEPTH must be a power of two and at least 2 so the pointers wrap naturally.
module verinject_injection_sequencer #(
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned TIME_W    = 32,
    parameter logic [31:0] IDLE_CODE = 32'hFFFF_FFFF
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    run,
    input  logic                    clear,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [TIME_W-1:0]       cmd_time,
    input  logic [31:0]             cmd_bit,
    output logic [31:0]             verinject__injector_state,
    output logic [TIME_W-1:0]       cycle_count,
    output logic [$clog2(DEPTH):0]  pending,
    output logic [15:0]             inject_count,
    output logic [15:0]             late_count,
    output logic                    halted
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    localparam logic [CNT_W-1:0]  FULL_LEVEL    = CNT_W'(DEPTH);
    localparam logic [TIME_W-1:0] TIME_LAST     = {TIME_W{1'b1}};
    localparam logic [TIME_W-1:0] TIME_PRE_LAST = TIME_LAST - TIME_W'(1);
    localparam logic [15:0]       STAT_MAX      = 16'hFFFF;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUNNING = 2'd1,
        ST_HALTED  = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;

    // Command storage, split into timestamp and bit-index columns.
    logic [TIME_W-1:0] fifo_time [DEPTH];
    logic [31:0]       fifo_bit  [DEPTH];

    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [CNT_W-1:0]  pending_q;

    logic [TIME_W-1:0] count_q;
    logic [31:0]       bus_q;
    logic [15:0]       inject_q;
    logic [15:0]       late_q;

    // Decoded control.
    logic              advance;
    logic              halted_dec;
    logic              fifo_empty;
    logic              fifo_full;
    logic [TIME_W-1:0] head_time;
    logic [31:0]       head_bit;
    logic              head_due;
    logic              head_late;
    logic              push;
    logic              pop;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next-state logic; halting happens on the step that lands on the
    // last counter value, so the counter never wraps.
    always_comb begin
        // NOTE: a default assignment first keeps every path driven and
        // prevents latch inference in combinational blocks.
        state_d = state_q;
        if (clear) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE, ST_RUNNING: begin
                    if (run) begin
                        state_d = (count_q == TIME_PRE_LAST) ? ST_HALTED : ST_RUNNING;
                    end
                end
                ST_HALTED: state_d = ST_HALTED;
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    // FSM: output decode; the first run cycle out of IDLE already counts.
    always_comb begin
        advance    = 1'b0;
        halted_dec = 1'b0;
        case (state_q)
            ST_IDLE, ST_RUNNING: advance    = run;
            ST_HALTED:           halted_dec = 1'b1;
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // FIFO status and head-of-queue timing compare
    // ------------------------------------------------------------------
    // Occupancy flags and due/late tests against the pre-increment count.
    always_comb begin
        fifo_empty = (pending_q == '0);
        fifo_full  = (pending_q == FULL_LEVEL);
        head_time  = fifo_time[rd_ptr_q];
        head_bit   = fifo_bit[rd_ptr_q];
        head_due   = !fifo_empty && (head_time <= count_q);
        head_late  = !fifo_empty && (head_time <  count_q);
    end

    // Ready depends only on registered occupancy, so a pop in a full cycle
    // does not open the door for a push in that same cycle.
    assign cmd_ready = !fifo_full;
    assign push      = cmd_valid && cmd_ready && !clear;
    assign pop       = advance && head_due && !clear;

    // Pointer and occupancy tracking; a simultaneous push and pop keeps the
    // level unchanged.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            pending_q <= '0;
        end else if (clear) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            pending_q <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   pending_q <= pending_q + CNT_W'(1);
                2'b01:   pending_q <= pending_q - CNT_W'(1);
                default: pending_q <= pending_q;
            endcase
        end
    end

    // Command storage write port.
    // NOTE: the storage array is deliberately not reset; an entry is only
    // read after it has been written, and leaving it unreset keeps it a
    // plain memory rather than a bank of resettable flops.
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_time[wr_ptr_q] <= cmd_time;
            fifo_bit[wr_ptr_q]  <= cmd_bit;
        end
    end

    // ------------------------------------------------------------------
    // Cycle counter, state bus and statistics
    // ------------------------------------------------------------------
    // Free-running cycle counter; advance is never asserted once halted.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (advance) begin
            count_q <= count_q + TIME_W'(1);
        end
    end

    // Registered injector state bus: one clock of the issued bit index,
    // otherwise the idle code.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bus_q <= IDLE_CODE;
        end else if (clear) begin
            bus_q <= IDLE_CODE;
        end else if (pop) begin
            bus_q <= head_bit;
        end else begin
            bus_q <= IDLE_CODE;
        end
    end

    // Saturating issue and late-issue statistics.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            inject_q <= '0;
            late_q   <= '0;
        end else if (clear) begin
            inject_q <= '0;
            late_q   <= '0;
        end else if (pop) begin
            if (inject_q != STAT_MAX) begin
                inject_q <= inject_q + 16'd1;
            end
            if (head_late && (late_q != STAT_MAX)) begin
                late_q <= late_q + 16'd1;
            end
        end
    end

    assign verinject__injector_state = bus_q;
    assign cycle_count               = count_q;
    assign pending                   = pending_q;
    assign inject_count              = inject_q;
    assign late_count                = late_q;
    assign halted                    = halted_dec;

endmodule

// File: tb/tb_verinject_injection_sequencer.sv
// Self-checking bench for verinject_injection_sequencer.
// A queue-based behavioural model tracks the expected bus, counter, FIFO
// occupancy and statistics; a second instance with a 4-bit counter is used
// to exercise halting.
module tb_verinject_injection_sequencer;

    localparam int          DEPTH = 8;
    localparam logic [31:0] IDLE  = 32'hFFFF_FFFF;

    typedef struct packed {
        logic [31:0] t;
        logic [31:0] b;
    } cmd_t;

    logic clock;
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Main instance (32-bit counter)
    logic        reset, run, clear, cmd_valid, cmd_ready, halted;
    logic [31:0] cmd_time, cmd_bit, state_bus, cycle_count;
    logic [3:0]  pending;
    logic [15:0] inject_count, late_count;

    // Halt instance (4-bit counter)
    logic        h_reset, h_run, h_clear, h_valid, h_ready, h_halted;
    logic [3:0]  h_time, h_count, h_pending;
    logic [31:0] h_bit, h_bus;
    logic [15:0] h_inject, h_late;

    verinject_injection_sequencer #(.DEPTH(DEPTH), .TIME_W(32), .IDLE_CODE(IDLE)) dut (
        .clock(clock), .reset(reset), .run(run), .clear(clear),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_time(cmd_time), .cmd_bit(cmd_bit),
        .verinject__injector_state(state_bus), .cycle_count(cycle_count), .pending(pending),
        .inject_count(inject_count), .late_count(late_count), .halted(halted)
    );

    verinject_injection_sequencer #(.DEPTH(DEPTH), .TIME_W(4), .IDLE_CODE(IDLE)) dut_halt (
        .clock(clock), .reset(h_reset), .run(h_run), .clear(h_clear),
        .cmd_valid(h_valid), .cmd_ready(h_ready), .cmd_time(h_time), .cmd_bit(h_bit),
        .verinject__injector_state(h_bus), .cycle_count(h_count), .pending(h_pending),
        .inject_count(h_inject), .late_count(h_late), .halted(h_halted)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural reference model
    cmd_t        m_q[$];
    logic [31:0] m_count, m_bus;
    logic [15:0] m_inject, m_late;
    logic        m_halted;

    task automatic m_reset();
        m_q.delete();
        m_count  = 0;
        m_bus    = IDLE;
        m_inject = 0;
        m_late   = 0;
        m_halted = 0;
    endtask

    // One clock of the specification's rules, using the inputs seen at the edge.
    task automatic m_step();
        logic accept;
        cmd_t c;
        accept = cmd_valid && (m_q.size() != DEPTH);
        if (clear) begin
            m_reset();
            return;
        end
        m_bus = IDLE;
        if (run && !m_halted) begin
            if (m_q.size() != 0 && m_q[0].t <= m_count) begin
                m_bus = m_q[0].b;
                if (m_inject != 16'hFFFF) m_inject = m_inject + 16'd1;
                if (m_q[0].t < m_count && m_late != 16'hFFFF) m_late = m_late + 16'd1;
                void'(m_q.pop_front());
            end
            m_count = m_count + 32'd1;
            if (m_count == 32'hFFFF_FFFF) m_halted = 1;
        end
        if (accept) begin
            c.t = cmd_time;
            c.b = cmd_bit;
            m_q.push_back(c);
        end
    endtask

    // Advance one clock: model follows the edge, return at the falling edge.
    task automatic tick();
        @(posedge clock);
        m_step();
        @(negedge clock);
    endtask

    task automatic do_clear();
        clear = 1;
        tick();
        clear = 0;
    endtask

    task automatic push_cmd(input logic [31:0] t, input logic [31:0] b);
        cmd_valid = 1;
        cmd_time  = t;
        cmd_bit   = b;
        tick();
        cmd_valid = 0;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        run = 0; clear = 0; cmd_valid = 0; cmd_time = 0; cmd_bit = 0;
        h_run = 0; h_clear = 0; h_valid = 0; h_time = 0; h_bit = 0;
        reset = 0; h_reset = 0;
        #1;
        reset = 1; h_reset = 1;
        #2;
        n_checks++; if (state_bus !== IDLE) begin n_fail++; $display("FAIL reset_bus: got %h expected %h", state_bus, IDLE); end
        n_checks++; if (cycle_count !== 32'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", cycle_count); end
        n_checks++; if (pending !== 4'd0) begin n_fail++; $display("FAIL reset_pending: got %0d expected 0", pending); end
        n_checks++; if (inject_count !== 16'd0 || late_count !== 16'd0) begin n_fail++; $display("FAIL reset_stats: got %0d/%0d expected 0/0", inject_count, late_count); end
        n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted: got %b expected 0", halted); end
        n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", cmd_ready); end
        @(negedge clock);
        reset = 0;
        m_reset();
        tick();
        n_checks++; if (cycle_count !== 32'd0) begin n_fail++; $display("FAIL reset_norun_count: got %0d expected 0", cycle_count); end
    endtask

    task automatic test_idle_run();
        run = 1;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_checks++; if (state_bus !== m_bus) begin n_fail++; $display("FAIL idle_bus: got %h expected %h", state_bus, m_bus); end
        end
        run = 0;
        n_checks++; if (cycle_count !== 32'd10) begin n_fail++; $display("FAIL idle_count: got %0d expected 10", cycle_count); end
        n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL idle_ready: got %b expected 1", cmd_ready); end
    endtask

    task automatic test_single();
        int hits, seen;
        do_clear();
        push_cmd(32'd5, 32'd3);
        run = 1; hits = 0; seen = -1;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_checks++; if (state_bus !== m_bus) begin n_fail++; $display("FAIL single_bus: got %h expected %h", state_bus, m_bus); end
            if (state_bus == 32'd3) begin hits++; seen = int'(cycle_count); end
        end
        run = 0;
        n_checks++; if (hits != 1 || seen != 6) begin n_fail++; $display("FAIL single_timing: got hits=%0d at count %0d expected 1 at 6", hits, seen); end
        n_checks++; if (inject_count !== 16'd1 || late_count !== 16'd0) begin n_fail++; $display("FAIL single_stats: got %0d/%0d expected 1/0", inject_count, late_count); end
    endtask

    task automatic test_order();
        int s7, s9, s1;
        do_clear();
        push_cmd(32'd4, 32'd7);
        push_cmd(32'd4, 32'd9);
        push_cmd(32'd2, 32'd1);
        run = 1; s7 = -1; s9 = -1; s1 = -1;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_checks++; if (state_bus !== m_bus) begin n_fail++; $display("FAIL order_bus: got %h expected %h", state_bus, m_bus); end
            if (state_bus == 32'd7) s7 = int'(cycle_count);
            if (state_bus == 32'd9) s9 = int'(cycle_count);
            if (state_bus == 32'd1) s1 = int'(cycle_count);
        end
        run = 0;
        n_checks++; if (s7 != 5 || s9 != 6 || s1 != 7) begin n_fail++; $display("FAIL order_timing: got %0d/%0d/%0d expected 5/6/7", s7, s9, s1); end
        n_checks++; if (inject_count !== 16'd3 || late_count !== 16'd2) begin n_fail++; $display("FAIL order_stats: got %0d/%0d expected 3/2", inject_count, late_count); end
    endtask

    task automatic test_full();
        do_clear();
        for (int i = 0; i < 8; i++) push_cmd(32'(100 + i), 32'(10 + i));
        n_checks++; if (pending !== 4'd8) begin n_fail++; $display("FAIL full_pending: got %0d expected 8", pending); end
        n_checks++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready: got %b expected 0", cmd_ready); end
        push_cmd(32'd200, 32'd99);
        n_checks++; if (pending !== 4'd8) begin n_fail++; $display("FAIL full_ninth: got pending %0d expected 8", pending); end
        run = 1;
        for (int i = 0; i < 101; i++) begin
            tick();
            n_checks++; if (state_bus !== m_bus) begin n_fail++; $display("FAIL full_bus: got %h expected %h", state_bus, m_bus); end
        end
        n_checks++; if (cycle_count !== 32'd101 || state_bus !== 32'd10) begin n_fail++; $display("FAIL full_first_pop: got count %0d bus %h expected 101 and a", cycle_count, state_bus); end
        n_checks++; if (pending !== 4'd7 || cmd_ready !== 1'b1) begin n_fail++; $display("FAIL full_after_pop: got pending %0d ready %b expected 7 and 1", pending, cmd_ready); end
        for (int i = 0; i < 8; i++) begin
            tick();
            n_checks++; if (state_bus !== m_bus) begin n_fail++; $display("FAIL full_drain_bus: got %h expected %h", state_bus, m_bus); end
        end
        run = 0;
        n_checks++; if (pending !== 4'd0 || inject_count !== 16'd8 || late_count !== 16'd0) begin n_fail++; $display("FAIL full_drain: got pending %0d stats %0d/%0d expected 0 8/0", pending, inject_count, late_count); end
    endtask

    // Full FIFO with a pop every cycle and the host pushing continuously.
    task automatic test_back_to_back();
        do_clear();
        for (int i = 0; i < 8; i++) push_cmd(32'd0, 32'(i));
        run = 1; cmd_valid = 1; cmd_time = 0;
        for (int i = 0; i < 20; i++) begin
            n_checks++; if (cmd_ready !== (m_q.size() != DEPTH)) begin n_fail++; $display("FAIL b2b_ready: got %b expected %b", cmd_ready, m_q.size() != DEPTH); end
            cmd_bit = $urandom;
            tick();
            n_checks++; if (state_bus !== m_bus || int'(pending) != m_q.size()) begin n_fail++; $display("FAIL b2b_bus_pending: got %h/%0d expected %h/%0d", state_bus, pending, m_bus, m_q.size()); end
        end
        cmd_valid = 0; run = 0;
        n_checks++; if (inject_count !== m_inject || late_count !== m_late) begin n_fail++; $display("FAIL b2b_stats: got %0d/%0d expected %0d/%0d", inject_count, late_count, m_inject, m_late); end
    endtask

    task automatic test_pause_clear();
        int seen;
        do_clear();
        push_cmd(32'd20, 32'd0);
        run = 1;
        repeat (10) tick();
        run = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++; if (cycle_count !== 32'd10 || state_bus !== IDLE) begin n_fail++; $display("FAIL pause_hold: got count %0d bus %h expected 10 and idle", cycle_count, state_bus); end
        end
        run = 1; seen = -1;
        for (int i = 0; i < 12; i++) begin
            tick();
            n_checks++; if (state_bus !== m_bus) begin n_fail++; $display("FAIL pause_bus: got %h expected %h", state_bus, m_bus); end
            if (state_bus == 32'd0) seen = int'(cycle_count);
        end
        n_checks++; if (seen != 21) begin n_fail++; $display("FAIL pause_resume: got issue at %0d expected 21", seen); end
        push_cmd(32'd50, 32'd5);
        repeat (3) tick();
        do_clear();
        n_checks++; if (pending !== 4'd0 || cycle_count !== 32'd0 || state_bus !== IDLE) begin n_fail++; $display("FAIL clear_state: got pending %0d count %0d bus %h expected 0 0 idle", pending, cycle_count, state_bus); end
        n_checks++; if (inject_count !== 16'd0 || late_count !== 16'd0 || halted !== 1'b0) begin n_fail++; $display("FAIL clear_stats: got %0d/%0d halted %b expected 0/0 0", inject_count, late_count, halted); end
        run = 0;
    endtask

    task automatic test_random();
        logic [31:0] base;
        do_clear();
        for (int i = 0; i < 3000; i++) begin
            run       = ($urandom_range(0, 9) < 8);
            clear     = ($urandom_range(0, 499) == 0);
            cmd_valid = ($urandom_range(0, 9) < 4);
            base      = (m_count >= 32'd5) ? m_count - 32'd5 : 32'd0;
            cmd_time  = base + 32'($urandom_range(0, 30));
            cmd_bit   = $urandom;
            tick();
            n_checks++; if (state_bus !== m_bus) begin n_fail++; $display("FAIL rand_bus: got %h expected %h", state_bus, m_bus); end
            n_checks++; if (cycle_count !== m_count) begin n_fail++; $display("FAIL rand_count: got %0d expected %0d", cycle_count, m_count); end
            n_checks++; if (int'(pending) != m_q.size() || cmd_ready !== (m_q.size() != DEPTH)) begin n_fail++; $display("FAIL rand_fifo: got %0d/%b expected %0d", pending, cmd_ready, m_q.size()); end
            n_checks++; if (inject_count !== m_inject || late_count !== m_late) begin n_fail++; $display("FAIL rand_stats: got %0d/%0d expected %0d/%0d", inject_count, late_count, m_inject, m_late); end
        end
        run = 0; clear = 0; cmd_valid = 0;
    endtask

    task automatic test_halt();
        @(negedge clock);
        h_reset = 0;
        h_run = 1;
        repeat (14) @(negedge clock);
        n_checks++; if (h_halted !== 1'b0 || h_count !== 4'd14) begin n_fail++; $display("FAIL halt_before: got halted %b count %0d expected 0 14", h_halted, h_count); end
        @(negedge clock);
        n_checks++; if (h_halted !== 1'b1 || h_count !== 4'd15) begin n_fail++; $display("FAIL halt_reach: got halted %b count %0d expected 1 15", h_halted, h_count); end
        repeat (3) @(negedge clock);
        n_checks++; if (h_halted !== 1'b1 || h_count !== 4'd15) begin n_fail++; $display("FAIL halt_hold: got halted %b count %0d expected 1 15", h_halted, h_count); end
        h_valid = 1; h_time = 4'd3; h_bit = 32'd2;
        @(negedge clock);
        h_valid = 0;
        n_checks++; if (h_pending !== 4'd1) begin n_fail++; $display("FAIL halt_push: got pending %0d expected 1", h_pending); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            n_checks++; if (h_bus !== IDLE) begin n_fail++; $display("FAIL halt_bus: got %h expected %h", h_bus, IDLE); end
        end
        n_checks++; if (h_pending !== 4'd1 || h_inject !== 16'd0) begin n_fail++; $display("FAIL halt_noissue: got pending %0d inject %0d expected 1 0", h_pending, h_inject); end
        #2;
        h_reset = 1;
        #1;
        n_checks++; if (h_halted !== 1'b0 || h_count !== 4'd0 || h_pending !== 4'd0) begin n_fail++; $display("FAIL halt_async_reset: got halted %b count %0d pending %0d expected 0 0 0", h_halted, h_count, h_pending); end
        n_checks++; if (h_bus !== IDLE || h_ready !== 1'b1 || h_inject !== 16'd0 || h_late !== 16'd0) begin n_fail++; $display("FAIL halt_async_outputs: got bus %h ready %b stats %0d/%0d", h_bus, h_ready, h_inject, h_late); end
        @(negedge clock);
        h_reset = 0; h_run = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_idle_run();
        test_single();
        test_order();
        test_full();
        test_back_to_back();
        test_pause_clear();
        test_random();
        test_halt();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
